// File: rtl/vc_sw_alloc_pkg.sv
// Shared sizing helpers and types for the output-port VC/switch allocator.
// The typedefs describe the default configuration; modules size their own storage from their parameters.
package vc_alloc_pkg;

  localparam int NR_DEF  = 8;
  localparam int VCN_DEF = 2;
  localparam int CD_DEF  = 4;

  function automatic int cw_of(input int cd);
    return $clog2(cd + 1);
  endfunction

  function automatic int vw_of(input int vcn);
    return (vcn > 1) ? $clog2(vcn) : 1;
  endfunction

  function automatic int iw_of(input int nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

  localparam int CW_DEF = cw_of(CD_DEF);
  localparam int VW_DEF = vw_of(VCN_DEF);
  localparam int IW_DEF = iw_of(NR_DEF);

  typedef logic [CW_DEF-1:0] cred_t;
  typedef cred_t [VCN_DEF-1:0] cred_vec_t;

  typedef struct packed {
    logic              vld;
    logic [IW_DEF-1:0] id;
  } own_t;

endpackage

// File: rtl/vc_sw_alloc_rr_arb.sv
// Combinational round-robin arbiter: lowest eligible index at or after ptr wins, wrapping around.
module rr_arb #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot;
  logic [N-1:0] pick;

  // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  assign rot  = N'({elig, elig} >> ptr);
  assign pick = rot & (~rot + N'(1));
  assign gnt  = N'(({pick, pick} << ptr) >> N);

endmodule

// File: rtl/vc_sw_alloc.sv
// Output-port allocator: VC allocation for head flits, per-flit switch arbitration, per-VC credit tracking.
// Grant is combinational from registered owner/credit/pointer state.
module vc_sw_alloc
  import vc_alloc_pkg::*;
#(
  parameter int NR  = NR_DEF,
  parameter int VCN = VCN_DEF,
  parameter int CD  = CD_DEF,
  parameter int CW  = cw_of(CD),
  parameter int VW  = vw_of(VCN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NR-1:0]  req,
  input  logic [NR-1:0]  hd,
  input  logic [NR-1:0]  tl,
  output logic [NR-1:0]  gnt,
  output logic           gvld,
  output logic [VW-1:0]  gvc,
  input  logic [VCN-1:0] cret,
  output logic [VCN-1:0] vcbusy,
  output logic           err
);

  localparam int IW = iw_of(NR);

  logic [CW-1:0]  cred    [VCN];
  logic [VCN-1:0] own_vld;
  logic [IW-1:0]  own_id  [VCN];
  logic [IW-1:0]  ptr;
  logic           err_q;

  logic           free_any;
  logic [VW-1:0]  free_vc;
  logic [NR-1:0]  own_hit;
  logic [NR-1:0]  own_ok;
  logic [VW-1:0]  own_vc  [NR];
  logic [VW-1:0]  tgt     [NR];
  logic [NR-1:0]  elig;
  logic [NR-1:0]  gnt_raw;
  logic           gvld_raw;
  logic [IW-1:0]  win;
  logic [VW-1:0]  gv;
  logic [VCN-1:0] dec;
  logic           ovf;
  logic           proto_err;
  logic [IW-1:0]  ptr_nxt;

  // lowest-index free VC that still has credit; only registered ownership counts
  always_comb begin
    free_any = 1'b0;
    free_vc  = '0;
    for (int v = VCN - 1; v >= 0; v--) begin
      if (!own_vld[v] && cred[v] != '0) begin
        free_any = 1'b1;
        free_vc  = VW'(v);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      own_hit[i] = 1'b0;
      own_ok[i]  = 1'b0;
      own_vc[i]  = '0;
      for (int v = 0; v < VCN; v++) begin
        if (own_vld[v] && own_id[v] == IW'(i)) begin
          own_hit[i] = 1'b1;
          own_ok[i]  = (cred[v] != '0);
          own_vc[i]  = VW'(v);
        end
      end
      elig[i] = req[i] & (hd[i] ? (~own_hit[i] & free_any) : own_ok[i]);
      tgt[i]  = hd[i] ? free_vc : own_vc[i];
    end
  end

  assign proto_err = |(req & hd & own_hit) | |(req & ~hd & ~own_hit);

  rr_arb #(.N(NR), .PW(IW)) u_arb (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (gnt_raw)
  );

  always_comb begin
    win = '0;
    gv  = '0;
    for (int i = 0; i < NR; i++) begin
      if (gnt_raw[i]) begin
        win = IW'(i);
        gv  = tgt[i];
      end
    end
  end

  assign gvld_raw = |gnt_raw;
  assign ptr_nxt  = (win == IW'(NR - 1)) ? '0 : win + IW'(1);

  always_comb begin
    ovf = 1'b0;
    for (int v = 0; v < VCN; v++) begin
      dec[v] = gvld_raw && (gv == VW'(v));
      if (cret[v] && !dec[v] && cred[v] == CW'(CD)) ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VCN; v++) begin
        cred[v]   <= CW'(CD);
        own_id[v] <= '0;
      end
      own_vld <= '0;
      ptr     <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int v = 0; v < VCN; v++) begin
        if (dec[v] && !cret[v]) cred[v] <= cred[v] - CW'(1);
        else if (cret[v] && !dec[v] && cred[v] != CW'(CD)) cred[v] <= cred[v] + CW'(1);
      end
      if (gvld_raw) begin
        ptr <= ptr_nxt;
        if (tl[win]) begin
          own_vld[gv] <= 1'b0;
        end else if (hd[win]) begin
          own_vld[gv] <= 1'b1;
          own_id[gv]  <= win;
        end
      end
      if (proto_err || ovf) err_q <= 1'b1;
    end
  end

  assign gnt    = rst ? '0 : gnt_raw;
  assign gvld   = rst ? 1'b0 : gvld_raw;
  assign gvc    = rst ? '0 : gv;
  assign vcbusy = own_vld;
  assign err    = err_q;

endmodule

// File: tb/tb_vc_sw_alloc.sv
// Directed bench for vc_sw_alloc: per-cycle vector table plus hand-written reset/credit sequences.
module tb_vc_sw_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] hd  = '0;
  logic [7:0] tl  = '0;
  logic [1:0] cret = '0;
  logic [7:0] gnt;
  logic       gvld;
  logic [0:0] gvc;
  logic [1:0] vcbusy;
  logic       err;

  int checks = 0;
  int errors = 0;

  vc_sw_alloc #(.NR(8), .VCN(2), .CD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .hd     (hd),
    .tl     (tl),
    .gnt    (gnt),
    .gvld   (gvld),
    .gvc    (gvc),
    .cret   (cret),
    .vcbusy (vcbusy),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rs;
    logic [7:0] req, hd, tl;
    logic [1:0] cret;
    logic [7:0] egnt;
    logic       egvc;
    logic [1:0] ebusy;
    logic       eerr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rs, input logic [7:0] r, input logic [7:0] h, input logic [7:0] t,
                     input logic [1:0] c, input logic [7:0] eg, input logic ev,
                     input logic [1:0] eb, input logic ee);
    vec_t x;
    x.rs = rs; x.req = r; x.hd = h; x.tl = t; x.cret = c;
    x.egnt = eg; x.egvc = ev; x.ebusy = eb; x.eerr = ee;
    tv.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] h, input logic [7:0] t, input logic [1:0] c);
    req = r; hd = h; tl = t; cret = c;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(8'h00, 8'h00, 8'h00, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // rs, req, hd, tl, cret | gnt, gvc, vcbusy, err   (busy/err are the values before the edge)
    add(0, 8'h01, 8'h01, 8'h00, 2'b00, 8'h01, 1'b0, 2'b00, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h01, 2'b01, 8'h00, 1'b0, 2'b01, 1'b0);
    add(0, 8'h01, 8'h00, 8'h01, 2'b00, 8'h01, 1'b0, 2'b01, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 2'b00, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 2'b00, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 2'b00, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 2'b00, 1'b0);
    // two heads, both VCs free; round-robin then pointer after r2
    add(1, 8'h05, 8'h05, 8'h00, 2'b00, 8'h01, 1'b0, 2'b00, 1'b0);
    add(0, 8'h04, 8'h04, 8'h00, 2'b00, 8'h04, 1'b1, 2'b01, 1'b0);
    add(0, 8'h05, 8'h00, 8'h00, 2'b00, 8'h01, 1'b0, 2'b11, 1'b0);
    add(0, 8'h05, 8'h00, 8'h00, 2'b00, 8'h04, 1'b1, 2'b11, 1'b0);
    add(0, 8'h04, 8'h00, 8'h04, 2'b00, 8'h04, 1'b1, 2'b11, 1'b0);
    add(0, 8'h01, 8'h01, 8'h00, 2'b00, 8'h00, 1'b0, 2'b01, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 2'b01, 1'b1);
    // single-flit packet, then prove VC0 was left with CD-1 credits
    add(1, 8'h08, 8'h08, 8'h08, 2'b00, 8'h08, 1'b0, 2'b00, 1'b0);
    add(0, 8'h02, 8'h02, 8'h00, 2'b00, 8'h02, 1'b0, 2'b00, 1'b0);
    add(0, 8'h02, 8'h00, 8'h00, 2'b00, 8'h02, 1'b0, 2'b01, 1'b0);
    add(0, 8'h02, 8'h00, 8'h00, 2'b00, 8'h02, 1'b0, 2'b01, 1'b0);
    add(0, 8'h02, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 2'b01, 1'b0);
    // grant + return on VC1 together, then overflow return
    add(0, 8'h10, 8'h10, 8'h00, 2'b10, 8'h10, 1'b1, 2'b01, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00, 1'b0, 2'b11, 1'b0);
    add(0, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 2'b11, 1'b1);
    add(0, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 2'b11, 1'b1);

    #2;
    chk("reset vcbusy", 32'(vcbusy), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset gvld", 32'(gvld), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < tv.size(); k++) begin
      if (tv[k].rs) do_reset();
      else begin
        @(posedge clk); #1;
      end
      drive(tv[k].req, tv[k].hd, tv[k].tl, tv[k].cret);
      @(negedge clk);
      chk($sformatf("v%0d gnt", k), 32'(gnt), 32'(tv[k].egnt));
      chk($sformatf("v%0d gvld", k), 32'(gvld), 32'(tv[k].egnt != 8'h00));
      chk($sformatf("v%0d gvc", k), 32'(gvc), 32'(tv[k].egvc));
      chk($sformatf("v%0d vcbusy", k), 32'(vcbusy), 32'(tv[k].ebusy));
      chk($sformatf("v%0d err", k), 32'(err), 32'(tv[k].eerr));
    end

    // async reset while r1 owns VC1 mid-packet
    do_reset();
    drive(8'h01, 8'h01, 8'h00, 2'b00);
    @(negedge clk);
    chk("mp r0 head gnt", 32'(gnt), 32'h01);
    @(posedge clk); #1;
    drive(8'h02, 8'h02, 8'h00, 2'b00);
    @(negedge clk);
    chk("mp r1 head gnt", 32'(gnt), 32'h02);
    chk("mp r1 head gvc", 32'(gvc), 32'h1);
    @(posedge clk); #1;
    drive(8'h02, 8'h00, 8'h00, 2'b00);
    @(negedge clk);
    chk("mp r1 body gnt", 32'(gnt), 32'h02);
    chk("mp busy before rst", 32'(vcbusy), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("mp rst gnt", 32'(gnt), 32'h0);
    chk("mp rst gvld", 32'(gvld), 32'h0);
    chk("mp rst gvc", 32'(gvc), 32'h0);
    chk("mp rst vcbusy", 32'(vcbusy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mp post body gnt", 32'(gnt), 32'h0);
    chk("mp post vcbusy", 32'(vcbusy), 32'h0);
    chk("mp post err", 32'(err), 32'h0);
    @(posedge clk); #1;
    drive(8'h00, 8'h00, 8'h00, 2'b00);
    chk("mp body err", 32'(err), 32'h1);

    // after reset each VC holds CD credits: head + 3 bodies granted, 4th body stalls
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(8'h04, (k == 0) ? 8'h04 : 8'h00, 8'h00, 2'b00);
      @(negedge clk);
      chk($sformatf("cd flit%0d gnt", k), 32'(gnt), (k < 4) ? 32'h04 : 32'h0);
      @(posedge clk); #1;
    end
    drive(8'h00, 8'h00, 8'h00, 2'b00);
    @(negedge clk);
    chk("cd err", 32'(err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_sw_alloc.md
Name: vc_sw_alloc

Overview:
- Clocked allocator for one router output port. It shares the crossbar output and the downstream VCs between NR input-VC requesters.
- Combines VC allocation on head flits, per-flit switch arbitration, and credit tracking for each downstream VC.
- Sits between the input buffers' switch requests and the crossbar/output-port control.
- Each cycle it grants at most one flit, with a combinational grant and registered state.

Parameters:
- NR, 8, number of requesters (input ports × input VCs)
- VCN, 2, number of downstream VCs
- CD, 4, downstream buffer depth per VC, in flits (initial credit)
- CW, $clog2(CD+1), credit counter width (derived)
- VW, (VCN>1 ? $clog2(VCN) : 1), VC index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NR  requester i has a flit ready
- hd  in  NR  that flit is a head flit
- tl  in  NR  that flit is a tail flit; hd and tl may both be set for a single-flit packet
- gnt  out  NR  one-hot grant; the flit transfers in this cycle
- gvld  out  1  OR of gnt
- gvc  out  VW  downstream VC carrying the granted flit
- cret  in  VCN  credit return pulse, one per VC per cycle
- vcbusy  out  VCN  registered VC-owned flags
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst=1):
  - all credits = CD; all VCs free; owner table cleared; RR pointer = 0; err = 0.
  - gnt, gvld and gvc are forced to 0 while rst=1.
- Registered state:
  - cred[v], width CW.
  - own_vld[v] and own_id[v], the requester owning VC v.
  - ptr, the round-robin pointer.
  - err.
- Eligibility of requester i, evaluated combinationally:
  - body/tail flit (hd=0): i must own some VC v (own_vld[v] && own_id[v]==i) and cred[v]>0. The target is that v.
  - head flit (hd=1): i must own no VC, and some free VC with cred>0 must exist. The target is the lowest-index such VC.
  - a head flit from a current owner is never eligible; it sets err at the edge.
  - a body flit from a non-owner is never eligible; it sets err at the edge.
- Arbitration:
  - round-robin over eligible requesters, starting at ptr; one-hot gnt; gvc = target of the winner.
  - zero-latency: gnt is valid in the same cycle as req.
  - the requester holds req until it sees gnt.
- At the clock edge, when gvld=1 (winner w, target v):
  - cred[v] decrements.
  - ptr becomes (w+1) mod NR.
  - hd&!tl: own_vld[v]=1, own_id[v]=w.
  - tl (with or without hd): own_vld[v]=0.
  - a single-flit packet never records ownership.
- Ownership timing:
  - a VC released in cycle t becomes allocatable from cycle t+1.
  - a VC allocated in cycle t blocks other heads from cycle t+1.
  - combinational free status uses registered own_vld only.
- Credit return:
  - cret[v] increments cred[v].
  - a grant and a return on the same v in the same cycle leave cred unchanged.
  - a return with cred==CD (and no grant) saturates at CD and sets err.
- No requesters eligible: gnt=0, gvld=0, gvc=0; ptr holds.
- vcbusy = own_vld.
- err clears only on rst.
- Reset mid-packet: all ownership and credits reinitialise; the downstream router is reset with the same rst.

Decomposition:
- Package vc_alloc_pkg:
  - localparam helpers for CW/VW.
  - typedef of the credit vector and owner-table entry {vld, id[$clog2(NR)-1:0]}.
- Sub-module rr_arb #(N):
  - inputs: eligible vector, pointer.
  - output: one-hot grant.
  - purely combinational; the pointer register stays in the parent.
- Everything else is kept in vc_sw_alloc.

Test Plan:
- After reset, req=8'h01, hd=1, tl=0 -> gnt=8'h01, gvc=0; next cycle vcbusy=2'b01 and cred[0]=3.
- Requester 0 owns VC0 and sends 3 body flits with no cret -> granted while cred[0]>0; after cred[0]=0 its gnt=0 and no error. A cret[0] pulse then produces one more grant.
- req=8'h05 all heads, both VCs free -> r0 granted VC0 in cycle 1 and r2 granted VC1 in cycle 2; ptr=3 afterwards.
- hd=tl=1 single flit from r3 -> gnt=8'h08, gvc=0; vcbusy remains 00; cred[0]=CD-1.
- Grant on VC1 and cret[1] in the same cycle -> cred[1] unchanged. A cret[1] with cred[1]=4 -> cred stays 4 and err=1, sticky until rst.
- Assert rst asynchronously mid-packet while r1 owns VC1 -> gnt=0 immediately; after release vcbusy=0, creds=4, err=0, and a body flit from r1 is not granted and sets err.
